// File: rtl/dedisp_ctrl.sv
// De-dispersion datapath sequencer: table load, read-back verify, then
// integration mode with a first-word-fall-through result FIFO toward the ARM.
module dedisp_ctrl #(
  parameter int BITWIDTH = 7,
  parameter int RD_LAT   = 3,
  parameter int FIFO_AW  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_start,
  input  logic                  cfg_wr,
  input  logic [15:0]           cfg_data,
  output logic                  arm_en,
  output logic [15:0]           para,
  output logic [BITWIDTH+1:0]   para_addr,
  output logic [BITWIDTH+1:0]   para_raddr,
  input  logic [15:0]           para_out,
  input  logic                  dready,
  input  logic [23:0]           power_com_out,
  input  logic [39:0]           time_output,
  output logic                  rec_valid,
  output logic [23:0]           rec_power,
  output logic [39:0]           rec_time,
  input  logic                  rec_ack,
  output logic [2:0]            state_o,
  output logic [15:0]           ovf_cnt
);

  localparam int AW = BITWIDTH + 2;
  localparam int N  = 1 << AW;
  localparam int VW = $clog2(N + RD_LAT + 1);
  localparam int FD = 1 << FIFO_AW;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_VERIFY = 3'd2,
    S_RUN    = 3'd3,
    S_ERR    = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [AW-1:0]     wcnt;
  logic [VW-1:0]     vcnt;
  logic [25:0]       wsum;
  logic [25:0]       rsum;
  logic [25:0]       rsum_nxt;
  logic [RD_LAT-1:0] vld_dl;
  logic              last_wr;
  logic              verify_done;
  logic              issue;

  logic [63:0]        fmem [FD];
  logic [FIFO_AW-1:0] wptr;
  logic [FIFO_AW-1:0] rptr;
  logic [FIFO_AW-1:0] rptr_nxt;
  logic [FIFO_AW:0]   fcnt;
  logic [FIFO_AW:0]   fcnt_nxt;
  logic               full;
  logic               push_req;
  logic               push;
  logic               pop;

  assign state_o = state;

  // Sequencing conditions; the final compare folds in the last read-back word
  // so the decision lands exactly N+RD_LAT cycles after entering VERIFY.
  always_comb begin
    last_wr     = (state == S_LOAD) && cfg_wr && (wcnt == '1);
    verify_done = (state == S_VERIFY) && (vcnt == VW'(N + RD_LAT - 1));
    issue       = (state == S_VERIFY) && (vcnt < VW'(N));
    rsum_nxt    = rsum + (vld_dl[RD_LAT-1] ? 26'(para_out) : '0);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and mode output; cfg_start overrides everything else.
  always_comb begin
    state_nxt = state;
    arm_en    = 1'b0;
    case (state)
      S_IDLE:   state_nxt = S_IDLE;
      S_LOAD:   if (last_wr) state_nxt = S_VERIFY;
      S_VERIFY: if (verify_done) state_nxt = (rsum_nxt == wsum) ? S_RUN : S_ERR;
      S_RUN:    arm_en = 1'b1;
      S_ERR:    state_nxt = S_ERR;
      default:  state_nxt = S_IDLE;
    endcase
    if (cfg_start) state_nxt = S_LOAD;
  end

  // Table write path, write checksum, read-back sweep and read checksum.
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt       <= '0;
      vcnt       <= '0;
      wsum       <= '0;
      rsum       <= '0;
      vld_dl     <= '0;
      para       <= '0;
      para_addr  <= '0;
      para_raddr <= '0;
    end else if (cfg_start) begin
      wcnt   <= '0;
      vcnt   <= '0;
      wsum   <= '0;
      rsum   <= '0;
      vld_dl <= '0;
    end else begin
      if (state == S_LOAD && cfg_wr) begin
        para      <= cfg_data;
        para_addr <= wcnt;
        wsum      <= wsum + 26'(cfg_data);
        wcnt      <= wcnt + AW'(1);
      end
      if (last_wr) begin
        vcnt       <= '0;
        para_raddr <= '0;
        rsum       <= '0;
        vld_dl     <= '0;
      end
      if (state == S_VERIFY) begin
        para_raddr <= para_raddr + AW'(1);
        if (!verify_done) vcnt <= vcnt + VW'(1);
        rsum <= rsum_nxt;
        vld_dl[0] <= issue;
        for (int unsigned i = RD_LAT - 1; i > 0; i--) vld_dl[i] <= vld_dl[i-1];
      end
    end
  end

  // FIFO control; a pop frees the slot a same-cycle push into a full FIFO needs.
  always_comb begin
    full     = (fcnt == (FIFO_AW+1)'(FD));
    push_req = (state == S_RUN) && dready && !cfg_start;
    pop      = rec_valid && rec_ack && !cfg_start;
    push     = push_req && (!full || pop);
    rptr_nxt = pop ? rptr + FIFO_AW'(1) : rptr;
    fcnt_nxt = fcnt;
    if (push && !pop)      fcnt_nxt = fcnt + (FIFO_AW+1)'(1);
    else if (!push && pop) fcnt_nxt = fcnt - (FIFO_AW+1)'(1);
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    if (push) fmem[wptr] <= {power_com_out, time_output};
  end

  // FIFO pointers, registered head (bypassed when pushing into an empty
  // FIFO) and saturating overflow counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      fcnt      <= '0;
      rec_valid <= 1'b0;
      rec_power <= '0;
      rec_time  <= '0;
      ovf_cnt   <= '0;
    end else if (cfg_start) begin
      wptr      <= '0;
      rptr      <= '0;
      fcnt      <= '0;
      rec_valid <= 1'b0;
    end else begin
      if (push) wptr <= wptr + FIFO_AW'(1);
      rptr      <= rptr_nxt;
      fcnt      <= fcnt_nxt;
      rec_valid <= (fcnt_nxt != '0);
      if (fcnt_nxt != '0) begin
        if (push && fcnt_nxt == (FIFO_AW+1)'(1)) {rec_power, rec_time} <= {power_com_out, time_output};
        else                                     {rec_power, rec_time} <= fmem[rptr_nxt];
      end
      if (push_req && full && !pop && ovf_cnt != '1) ovf_cnt <= ovf_cnt + 16'd1;
    end
  end

endmodule
